// File: rtl/adc_pkg.sv
// Shared definitions for the servo-position ADC serial front end.
// Frame geometry defaults are also used by the servo control logic.
package adc_pkg;

    localparam int unsigned ADC_FRAME_BITS = 16;
    localparam int unsigned ADC_DATA_W     = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_DONE,
        ST_QUIET
    } adc_state_t;

endpackage

// File: rtl/adc_bit_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both stages clear to 0 on the asynchronous active-low reset.
module adc_bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_serial_reader.sv
// AD7476-class serial reader: frames a conversion with cs_n, forwards a gated
// SCLK and shifts in one 16-bit frame, delivering a 12-bit sample with a strobe.
module adc_serial_reader
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W      = ADC_DATA_W,
    parameter int unsigned FRAME_BITS  = ADC_FRAME_BITS,
    parameter int unsigned QUIET_TICKS = 2
) (
    input  logic              Clck_in,
    input  logic              reset_Clock_n,
    input  logic              sclk_div,
    input  logic              enable,
    input  logic              sdata,
    output logic              cs_n,
    output logic              sclk_adc,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              frame_err
);

    localparam int unsigned BIT_W  = $clog2(FRAME_BITS);
    localparam int unsigned QCNT_W = $clog2(QUIET_TICKS + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_BITS - 1);
    localparam logic [QCNT_W-1:0] QUIET_LAST = QCNT_W'(QUIET_TICKS - 1);

    adc_state_t            state, state_next;
    logic                  sclk_q;
    logic                  sdata_s;
    logic                  rise_tick, fall_tick;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_next;
    logic [QCNT_W-1:0]     quiet_cnt, quiet_cnt_next;
    logic [FRAME_BITS-1:0] shreg, shreg_next;

    adc_bit_sync u_sdata_sync (
        .clk   (Clck_in),
        .rst_n (reset_Clock_n),
        .d     (sdata),
        .q     (sdata_s)
    );

    assign rise_tick = sclk_div & ~sclk_q;
    assign fall_tick = ~sclk_div & sclk_q;

    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        quiet_cnt_next = quiet_cnt;
        shreg_next     = shreg;
        case (state)
            ST_IDLE: begin
                if (enable && fall_tick) state_next = ST_CS_SETUP;
            end
            ST_CS_SETUP: begin
                if (rise_tick) begin
                    state_next   = ST_SHIFT;
                    bit_cnt_next = '0;
                end
            end
            ST_SHIFT: begin
                if (fall_tick) begin
                    shreg_next = {shreg[FRAME_BITS-2:0], sdata_s};
                    if (bit_cnt == BIT_LAST) state_next = ST_DONE;
                    else                     bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_next     = ST_QUIET;
                quiet_cnt_next = '0;
            end
            ST_QUIET: begin
                if (rise_tick) begin
                    quiet_cnt_next = quiet_cnt + 1'b1;
                    if (quiet_cnt == QUIET_LAST) state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state
    // they belong to; the sample is captured on entry to DONE so data_out is
    // already valid while data_valid is high.
    always_ff @(posedge Clck_in or negedge reset_Clock_n) begin
        if (!reset_Clock_n) begin
            state      <= ST_IDLE;
            sclk_q     <= 1'b0;
            bit_cnt    <= '0;
            quiet_cnt  <= '0;
            shreg      <= '0;
            cs_n       <= 1'b1;
            sclk_adc   <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            sclk_q     <= sclk_div;
            bit_cnt    <= bit_cnt_next;
            quiet_cnt  <= quiet_cnt_next;
            shreg      <= shreg_next;
            cs_n       <= !((state_next == ST_CS_SETUP) || (state_next == ST_SHIFT));
            busy       <= (state_next != ST_IDLE);
            sclk_adc   <= (state == ST_SHIFT) ? sclk_q : 1'b1;
            data_valid <= (state_next == ST_DONE);
            if (state_next == ST_DONE) begin
                data_out  <= shreg_next[DATA_W-1:0];
                frame_err <= |shreg_next[FRAME_BITS-1:DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Scoreboard bench for adc_serial_reader with a behavioural AD7476 pin model.
module tb_adc_serial_reader;

    localparam int unsigned DATA_W      = 12;
    localparam int unsigned FRAME_BITS  = 16;
    localparam int unsigned QUIET_TICKS = 2;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              sclk_div;
    logic              enable;
    logic              sdata;
    logic              cs_n;
    logic              sclk_adc;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              busy;
    logic              frame_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic [FRAME_BITS-1:0] adc_q[$];

    int   sclk_half = 4;
    logic sclk_run  = 1'b1;

    adc_serial_reader #(
        .DATA_W      (DATA_W),
        .FRAME_BITS  (FRAME_BITS),
        .QUIET_TICKS (QUIET_TICKS)
    ) dut (
        .Clck_in       (clk),
        .reset_Clock_n (rst_n),
        .sclk_div      (sclk_div),
        .enable        (enable),
        .sdata         (sdata),
        .cs_n          (cs_n),
        .sclk_adc      (sclk_adc),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        sclk_div = 1'b1;
        forever begin
            repeat (sclk_half) @(posedge clk);
            #2;
            if (sclk_run) sclk_div = ~sclk_div;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ADC pin model: first bit appears on cs_n fall, next bit on each SCLK fall.
    logic [FRAME_BITS-1:0] cur_word = '0;
    int bit_idx = 0;
    initial sdata = 1'b0;
    always @(negedge cs_n) begin
        cur_word = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
        bit_idx  = 0;
        sdata    = cur_word[FRAME_BITS-1];
    end
    always @(negedge sclk_adc) begin
        if (!cs_n && bit_idx < FRAME_BITS - 1) begin
            bit_idx++;
            sdata = cur_word[FRAME_BITS-1-bit_idx];
        end
    end

    // Monitor: scoreboard pops on data_valid, plus pin-level frame checks.
    logic prev_cs_n = 1'b1, prev_sclk_adc = 1'b1, prev_sclk_div = 1'b1, prev_valid = 1'b0;
    int   fall_cnt = 0;
    int   quiet_rises = QUIET_TICKS;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            fall_cnt    = 0;
            quiet_rises = QUIET_TICKS;
        end else begin
            if (data_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", 32'(data_out), 32'(e.data));
                    check("frame_err", 32'(frame_err), 32'(e.err));
                end
                check("valid_single_cycle", 32'(prev_valid), 32'd0);
                check("valid_busy", 32'(busy), 32'd1);
            end
            if (!cs_n && prev_sclk_adc && !sclk_adc) fall_cnt++;
            if (prev_cs_n && !cs_n) begin
                check("quiet_gap_ok", 32'(quiet_rises >= QUIET_TICKS), 32'd1);
                quiet_rises = 0;
                fall_cnt    = 0;
            end
            if (!prev_cs_n && cs_n) check("frame_sclk_falls", 32'(fall_cnt), 32'(FRAME_BITS - 1));
            if (cs_n && sclk_div && !prev_sclk_div) quiet_rises++;
            if (cs_n && !sclk_adc) check("sclk_idle_high", 32'(sclk_adc), 32'd1);
        end
        prev_cs_n     = cs_n;
        prev_sclk_adc = sclk_adc;
        prev_sclk_div = sclk_div;
        prev_valid    = data_valid;
    end

    task automatic send(input logic [FRAME_BITS-1:0] word);
        exp_t e;
        e.data = word[DATA_W-1:0];
        e.err  = |word[FRAME_BITS-1:DATA_W];
        adc_q.push_back(word);
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_cs_low(input int budget);
        int cyc = 0;
        while (cs_n !== 1'b0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (cs_n !== 1'b0) check("cs_low_timeout", 32'(cs_n), 32'd0);
    endtask

    task automatic wait_sclk_falls(input int n, input int budget);
        int   seen = 0;
        int   cyc  = 0;
        logic prev;
        prev = sclk_div;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            if (prev && !sclk_div) seen++;
            prev = sclk_div;
            cyc++;
        end
        if (seen < n) check("sclk_fall_timeout", 32'(seen), 32'(n));
    endtask

    task automatic set_enable(input logic v);
        @(posedge clk);
        #2 enable = v;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({cs_n, sclk_adc, busy, data_valid, frame_err, data_out}),
              32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {DATA_W{1'b0}}}));
    endtask

    initial begin
        logic             snap_cs, snap_busy;
        logic [FRAME_BITS-1:0] w;
        int               nfr;
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (40) begin
            @(negedge clk);
            check_reset_outputs("reset_hold");
        end
        enable = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);

        send(16'h0ABC);
        set_enable(1'b1);
        drain(600);
        set_enable(1'b0);
        repeat (60) @(posedge clk);

        send(16'h5FFF);
        set_enable(1'b1);
        drain(600);
        set_enable(1'b0);
        repeat (60) @(posedge clk);

        send(16'h0123);
        send(16'h0FED);
        set_enable(1'b1);
        drain(1200);
        set_enable(1'b0);
        repeat (60) @(posedge clk);

        send(16'h0456);
        set_enable(1'b1);
        wait_cs_low(200);
        wait_sclk_falls(5, 200);
        repeat (2) @(posedge clk);
        #2 enable = 1'b0;
        drain(600);
        repeat (30) @(posedge clk);
        repeat (8) begin
            repeat (10) @(negedge clk);
            check("idle_after_enable_drop", 32'({cs_n, busy}), 32'({1'b1, 1'b0}));
        end

        adc_q.push_back(16'h0AAA);
        set_enable(1'b1);
        wait_cs_low(200);
        wait_sclk_falls(8, 200);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_shift");
        send(16'h0777);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        drain(600);
        check("post_reset_sample", 32'(data_out), 32'h777);
        set_enable(1'b0);
        repeat (60) @(posedge clk);

        for (int g = 0; g < 6; g++) begin
            sclk_half = int'($urandom_range(3, 6));
            nfr = int'($urandom_range(1, 4));
            for (int f = 0; f < nfr; f++) begin
                w = 16'($urandom);
                if ($urandom_range(0, 3) != 0) w[FRAME_BITS-1:DATA_W] = '0;
                send(w);
            end
            set_enable(1'b1);
            if (g % 2 == 1) begin
                repeat ($urandom_range(20, 150)) @(posedge clk);
                #2 sclk_run = 1'b0;
                repeat (3) @(negedge clk);
                snap_cs   = cs_n;
                snap_busy = busy;
                repeat ($urandom_range(10, 40)) @(negedge clk);
                check("stall_stable", 32'({cs_n, busy, data_valid}), 32'({snap_cs, snap_busy, 1'b0}));
                @(posedge clk);
                #2 sclk_run = 1'b1;
            end
            drain(400 * nfr + 400);
            set_enable(1'b0);
            repeat (80) @(posedge clk);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
